// File: rtl/pc.sv
// pc: program-counter register with combinational PC+4 and an optional word-alignment check.
//     Define PC_ALIGN_CHECK_EN to flag misaligned next-PC values and force loads to word alignment.
module pc #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_plus4,
   output logic             misaligned
);
   logic [WIDTH-1:0] nxt;
`ifdef PC_ALIGN_CHECK_EN
   assign nxt        = {in[WIDTH-1:2], 2'b00};
   assign misaligned = |in[1:0];
`else
   assign nxt        = in;
   assign misaligned = 1'b0;
`endif
   // PC register: async reset to the reset vector, otherwise load on enable and hold on stall
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out <= RESET_VECTOR;
      else if (en) out <= nxt;
   assign out_plus4 = out + WIDTH'(4);
endmodule

// File: tb/tb_pc.sv
// tb_pc: randomized self-checking bench for pc against a behavioural next-PC model.
module tb_pc;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, run = 1'b0;
   logic [31:0] in = '0, out, out_plus4;
   logic        misaligned;
   logic [31:0] m = '0;
   int          checks = 0, errors = 0;

   pc #(.WIDTH(32), .RESET_VECTOR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in),
      .out(out), .out_plus4(out_plus4), .misaligned(misaligned)
   );

   always #50 if (run) clk = ~clk;

   function automatic logic [31:0] ld(input logic [31:0] x);
`ifdef PC_ALIGN_CHECK_EN
      return x & ~32'h3;
`else
      return x;
`endif
   endfunction

   function automatic logic exp_mis(input logic [31:0] x);
`ifdef PC_ALIGN_CHECK_EN
      return x[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk_pc(input string tag);
      chk({tag, ".out"}, out, m);
      chk({tag, ".plus4"}, out_plus4, m + 32'd4);
   endtask

   task automatic step();
      m = !rst_n ? 32'h0 : en ? ld(in) : m;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] v);
      en = 1'b1;
      in = v;
      step();
   endtask

   initial begin
      #1;
      chk_pc("rst_idle");
      rst_n = 1'b1;
      #10;
      chk_pc("rst_release");
      run = 1'b1;
      load(32'h8888_8888);
      chk("t2a", out_plus4, 32'h8888_888C);
      chk_pc("t2a");
      load(32'hC888_8888);
      chk("t2b", out_plus4, 32'hC888_888C);
      load(32'h0888_8888);
      chk("t2c", out_plus4, 32'h0888_888C);
      chk_pc("t2c");
      load(32'h1000);
      en = 1'b0;
      in = 32'h2000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall", out, 32'h1000);
      end
      in = 'x;
      step();
      chk_pc("stall_x");
      load(32'h2000);
      chk("unstall", out, 32'h2000);
      load(32'hC888_8888);
      #10;
      rst_n = 1'b0;
      m = 32'h0;
      #1;
      chk_pc("async_rst");
      en = 1'b1;
      in = 32'h44;
      step();
      chk_pc("rst_edge");
      #10;
      rst_n = 1'b1;
      #1;
      chk_pc("rst_hold");
      load(32'hFFFF_FFFC);
      chk("wrap", out_plus4, 32'h0);
      en = 1'b1;
      in = 32'h0000_1006;
      #1;
      chk("mis_flag", {31'b0, misaligned}, {31'b0, exp_mis(in)});
      step();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_load", out, 32'h0000_1004);
`else
      chk("mis_load", out, 32'h0000_1006);
`endif
      for (int i = 0; i < 300; i++) begin
         en = $urandom_range(0, 3) != 0;
         in = $urandom;
         #1;
         chk("rnd_mis", {31'b0, misaligned}, {31'b0, exp_mis(in)});
         if ($urandom_range(0, 19) == 0) begin
            #5;
            rst_n = 1'b0;
            m = 32'h0;
            #1;
            chk_pc("rnd_rst");
            #5;
            rst_n = 1'b1;
         end
         step();
         chk_pc("rnd");
         in = $urandom;
         #1;
         chk("rnd_between", out, m);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
